// File: rtl/ledseq_pkg.sv
// Shared constants and types for the LED pattern sequencer.
// Optional host override (CSR 3) is built only with LEDSEQ_HOST_OVERRIDE_EN.
package ledseq_pkg;

    localparam logic [3:0] ADDR_CTRL     = 4'd0;
    localparam logic [3:0] ADDR_PERIOD   = 4'd1;
    localparam logic [3:0] ADDR_STATUS   = 4'd2;
    localparam logic [3:0] ADDR_OVR      = 4'd3;
    localparam logic [3:0] ADDR_PAT_BASE = 4'd8;

    localparam int CTRL_RUN      = 0;
    localparam int CTRL_ONESHOT  = 1;
    localparam int CTRL_LAST_LSB = 4;
    localparam int STAT_BUSY     = 0;
    localparam int STAT_IDX_LSB  = 4;
    localparam int OVR_EN        = 8;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_WRITE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;

    typedef struct packed {
        logic [2:0] last;
        logic       oneshot;
        logic       run;
    } ctrl_t;

    function automatic logic [31:0] ctrl_word(input ctrl_t c);
        // NOTE: blocking assignments belong in functions and combinational logic only.
        ctrl_word                        = '0;
        ctrl_word[CTRL_RUN]              = c.run;
        ctrl_word[CTRL_ONESHOT]          = c.oneshot;
        ctrl_word[CTRL_LAST_LSB +: 3]    = c.last;
    endfunction

endpackage

// File: rtl/ledseq_if.sv
// Avalon-MM CSR slave bus and LED PIO write bus used by the sequencer.
interface ledseq_csr_if;
    logic [3:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (output address, chipselect, write_n, writedata, input readdata);
    modport slave  (input address, chipselect, write_n, writedata, output readdata);
endinterface

interface ledseq_pio_if;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;

    modport master (output address, chipselect, write_n, writedata);
    modport slave  (input address, chipselect, write_n, writedata);
endinterface

// File: rtl/ledseq_csr.sv
// Register file and combinational read mux for the LED sequencer.
// OVR register at address 3 exists only with LEDSEQ_HOST_OVERRIDE_EN.
module ledseq_csr
    import ledseq_pkg::*;
#(
    parameter  int DEPTH = 8,
    parameter  int CNT_W = 24,
    parameter  int LED_W = 8,
    localparam int IDX_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset_n,
    ledseq_csr_if.slave      csr,
    input  logic             busy,
    input  logic [IDX_W-1:0] idx,
    input  logic             clear_run,
    output ctrl_t            ctrl,
    output logic [CNT_W-1:0] period,
`ifdef LEDSEQ_HOST_OVERRIDE_EN
    output logic             ovr_en,
    output logic [LED_W-1:0] ovr_val,
    output logic             ovr_req,
`endif
    output logic [LED_W-1:0] pattern [DEPTH]
);

    localparam logic [2:0] LAST_MASK = 3'(DEPTH - 1);

    logic wr;
    logic pat_hit;

    assign wr      = csr.chipselect & ~csr.write_n;
    assign pat_hit = csr.address[3] && (int'(csr.address[2:0]) < DEPTH);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ctrl   <= '0;
            period <= '0;
            // NOTE: the pattern table is small flops, so it is reset to give a known first write.
            for (int i = 0; i < DEPTH; i++) pattern[i] <= '0;
        end else begin
            // A host CTRL write in the same cycle overrides the one-shot RUN clear.
            if (clear_run) ctrl.run <= 1'b0;
            if (wr && csr.address == ADDR_CTRL) begin
                ctrl.run     <= csr.writedata[CTRL_RUN];
                ctrl.oneshot <= csr.writedata[CTRL_ONESHOT];
                ctrl.last    <= csr.writedata[CTRL_LAST_LSB +: 3] & LAST_MASK;
            end
            if (wr && csr.address == ADDR_PERIOD) period <= csr.writedata[CNT_W-1:0];
            if (wr && pat_hit) pattern[csr.address[IDX_W-1:0]] <= csr.writedata[LED_W-1:0];
        end
    end

`ifdef LEDSEQ_HOST_OVERRIDE_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ovr_en  <= 1'b0;
            ovr_val <= '0;
            ovr_req <= 1'b0;
        end else begin
            // Request a PIO write for any OVR write while enabled or on the 1->0 release.
            ovr_req <= wr && csr.address == ADDR_OVR && (csr.writedata[OVR_EN] || ovr_en);
            if (wr && csr.address == ADDR_OVR) begin
                ovr_en  <= csr.writedata[OVR_EN];
                ovr_val <= csr.writedata[LED_W-1:0];
            end
        end
    end
`endif

    always_comb begin
        csr.readdata = '0;
        if (pat_hit) begin
            csr.readdata[LED_W-1:0] = pattern[csr.address[IDX_W-1:0]];
        end else begin
            case (csr.address)
                ADDR_CTRL:   csr.readdata = ctrl_word(ctrl);
                ADDR_PERIOD: csr.readdata[CNT_W-1:0] = period;
                ADDR_STATUS: begin
                    csr.readdata[STAT_BUSY]             = busy;
                    csr.readdata[STAT_IDX_LSB +: IDX_W] = idx;
                end
`ifdef LEDSEQ_HOST_OVERRIDE_EN
                ADDR_OVR: begin
                    csr.readdata[OVR_EN]    = ovr_en;
                    csr.readdata[LED_W-1:0] = ovr_val;
                end
`endif
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/pio_led_sequencer.sv
// Autonomous LED pattern sequencer: FSM, period counter and PIO write master.
// Host override of the LEDs is built only with LEDSEQ_HOST_OVERRIDE_EN.
module pio_led_sequencer
    import ledseq_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int CNT_W = 24,
    parameter int LED_W = 8
) (
    input  logic          clk,
    input  logic          reset_n,
    ledseq_csr_if.slave   csr,
    ledseq_pio_if.master  pio,
    output logic          busy
);

    localparam int IDX_W = $clog2(DEPTH);

    logic [1:0]       state;
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] last_idx;
    logic [CNT_W-1:0] counter;
    logic [CNT_W-1:0] reload;
    logic [CNT_W-1:0] period;
    logic [LED_W-1:0] pattern [DEPTH];
    logic [LED_W-1:0] held;
    logic [LED_W-1:0] wr_data;
    ctrl_t            ctrl;
    logic             clear_run;
    logic             freeze;
    logic             strobe;

`ifdef LEDSEQ_HOST_OVERRIDE_EN
    logic             ovr_en;
    logic [LED_W-1:0] ovr_val;
    logic             ovr_req;
`endif

    ledseq_csr #(.DEPTH(DEPTH), .CNT_W(CNT_W), .LED_W(LED_W)) u_csr (
        .clk       (clk),
        .reset_n   (reset_n),
        .csr       (csr),
        .busy      (busy),
        .idx       (idx),
        .clear_run (clear_run),
        .ctrl      (ctrl),
        .period    (period),
`ifdef LEDSEQ_HOST_OVERRIDE_EN
        .ovr_en    (ovr_en),
        .ovr_val   (ovr_val),
        .ovr_req   (ovr_req),
`endif
        .pattern   (pattern)
    );

    assign last_idx = ctrl.last[IDX_W-1:0];
    assign reload   = (period < CNT_W'(2)) ? '0 : period - CNT_W'(2);
    assign busy     = (state != ST_IDLE);

`ifdef LEDSEQ_HOST_OVERRIDE_EN
    // Override writes take the bus; the FSM stalls while they are pending or enabled.
    assign freeze  = ovr_en | ovr_req;
    assign strobe  = ovr_req | (state == ST_WRITE && !freeze);
    assign wr_data = (ovr_req && ovr_en) ? ovr_val : pattern[idx];
`else
    assign freeze  = 1'b0;
    assign strobe  = (state == ST_WRITE);
    assign wr_data = pattern[idx];
`endif

    assign clear_run = !freeze && state == ST_WAIT && ctrl.run && counter == '0
                       && idx == last_idx && ctrl.oneshot;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= ST_IDLE;
            idx     <= '0;
            counter <= '0;
            held    <= '0;
        end else begin
            if (strobe) held <= wr_data;
            if (!freeze) begin
                case (state)
                    ST_IDLE: if (ctrl.run) state <= ST_WRITE;
                    ST_WRITE: begin
                        if (!ctrl.run) begin
                            state <= ST_IDLE;
                            idx   <= '0;
                        end else begin
                            counter <= reload;
                            state   <= ST_WAIT;
                        end
                    end
                    ST_WAIT: begin
                        if (!ctrl.run) begin
                            state <= ST_IDLE;
                            idx   <= '0;
                        end else if (counter != '0) begin
                            counter <= counter - 1'b1;
                        end else if (idx == last_idx) begin
                            idx   <= '0;
                            state <= ctrl.oneshot ? ST_IDLE : ST_WRITE;
                        end else begin
                            idx   <= idx + 1'b1;
                            state <= ST_WRITE;
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

    assign pio.address    = 2'b00;
    assign pio.chipselect = strobe;
    assign pio.write_n    = ~strobe;
    assign pio.writedata  = {{(32-LED_W){1'b0}}, (strobe ? wr_data : held)};

endmodule

// File: tb/tb_pio_led_sequencer.sv
// Self-checking bench for pio_led_sequencer: CSR vector table plus sequence model.
`timescale 1ns/1ps
module tb_pio_led_sequencer;
    import ledseq_pkg::*;

    localparam int DEPTH = 8;
    localparam int CNT_W = 24;
    localparam int LED_W = 8;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic busy;

    ledseq_csr_if csr();
    ledseq_pio_if pio();

    pio_led_sequencer #(.DEPTH(DEPTH), .CNT_W(CNT_W), .LED_W(LED_W)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .csr     (csr),
        .pio     (pio),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int cap_t[$];
    logic [31:0] cap_d[$];
    logic [LED_W-1:0] pat_m [DEPTH];

    typedef struct {
        bit          wr;
        logic [3:0]  addr;
        logic [31:0] data;
        logic [31:0] exp;
    } vec_t;
    vec_t tbl[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Record every PIO write with the cycle it was seen in.
    always @(negedge clk) begin
        if (reset_n && pio.chipselect && !pio.write_n) begin
            cap_t.push_back(cyc);
            cap_d.push_back(pio.writedata);
            check("pio_address", 32'(pio.address), 32'd0);
        end
    end

    task automatic csr_write(input logic [3:0] a, input logic [31:0] d, output int commit);
        @(negedge clk);
        csr.address = a; csr.writedata = d; csr.chipselect = 1'b1; csr.write_n = 1'b0;
        @(negedge clk);
        csr.chipselect = 1'b0; csr.write_n = 1'b1;
        commit = cyc;
    endtask

    task automatic csr_read(input logic [3:0] a, output logic [31:0] d);
        @(negedge clk);
        csr.address = a; csr.chipselect = 1'b1; csr.write_n = 1'b1;
        #1 d = csr.readdata;
        csr.chipselect = 1'b0;
    endtask

    task automatic wait_writes(input int n, input int budget);
        for (int i = 0; i < budget && cap_d.size() < n; i++) @(negedge clk);
    endtask

    // Expected write k lands max(PERIOD,2)*k cycles after the first, which follows the CTRL commit by one.
    task automatic run_seq(input string name, input int period, input int last, input bit oneshot, input int nw);
        int e, k, p2;
        logic [31:0] d;
        p2 = (period < 2) ? 2 : period;
        csr_write(ADDR_PERIOD, 32'(period), k);
        cap_t.delete(); cap_d.delete();
        csr_write(ADDR_CTRL, 32'((last << 4) | (int'(oneshot) << 1) | 1), e);
        wait_writes(nw, nw * p2 + 20);
        if (oneshot) begin
            repeat (2 * p2 + 5) @(negedge clk);
            check($sformatf("%s write count", name), 32'(cap_d.size()), 32'(nw));
            check($sformatf("%s busy after", name), 32'(busy), 32'd0);
            csr_read(ADDR_CTRL, d);
            check($sformatf("%s ctrl after", name), d, 32'((last << 4) | 2));
            csr_write(ADDR_CTRL, 32'd0, k);
        end else begin
            csr_write(ADDR_CTRL, 32'(last << 4), k);
            repeat (4) @(negedge clk);
            check($sformatf("%s busy after stop", name), 32'(busy), 32'd0);
        end
        for (int j = 0; j < nw; j++) begin
            if (j < cap_d.size()) begin
                check($sformatf("%s w%0d time", name, j), 32'(cap_t[j]), 32'(e + 1 + j * p2));
                check($sformatf("%s w%0d data", name, j), cap_d[j], 32'(pat_m[j % (last + 1)]));
            end else begin
                check($sformatf("%s w%0d missing", name, j), 32'(cap_d.size()), 32'(j + 1));
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int e, e2;
        logic [31:0] d;
        csr.address = '0; csr.chipselect = 1'b0; csr.write_n = 1'b1; csr.writedata = '0;
        for (int i = 0; i < DEPTH; i++) pat_m[i] = '0;

        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check("rst pio_chipselect", 32'(pio.chipselect), 32'd0);
        check("rst pio_write_n", 32'(pio.write_n), 32'd1);
        check("rst pio_writedata", pio.writedata, 32'd0);
        check("rst busy", 32'(busy), 32'd0);

        for (int a = 0; a < 16; a++) tbl.push_back('{1'b0, 4'(a), 32'd0, 32'd0});
        tbl.push_back('{1'b1, ADDR_PERIOD, 32'hFFFF_FFFF, 32'd0});
        tbl.push_back('{1'b0, ADDR_PERIOD, 32'd0, 32'h00FF_FFFF});
        tbl.push_back('{1'b1, 4'd8, 32'h0000_01A5, 32'd0});
        tbl.push_back('{1'b0, 4'd8, 32'd0, 32'h0000_00A5});
        tbl.push_back('{1'b1, 4'd15, 32'h0000_003C, 32'd0});
        tbl.push_back('{1'b0, 4'd15, 32'd0, 32'h0000_003C});
        tbl.push_back('{1'b1, 4'd4, 32'h0000_FFFF, 32'd0});
        tbl.push_back('{1'b0, 4'd4, 32'd0, 32'd0});
        tbl.push_back('{1'b1, ADDR_STATUS, 32'h0000_00FF, 32'd0});
        tbl.push_back('{1'b0, ADDR_STATUS, 32'd0, 32'd0});
        tbl.push_back('{1'b1, ADDR_CTRL, 32'h0000_00FE, 32'd0});
        tbl.push_back('{1'b0, ADDR_CTRL, 32'd0, 32'h0000_0072});
        tbl.push_back('{1'b1, ADDR_CTRL, 32'd0, 32'd0});
        tbl.push_back('{1'b1, 4'd8, 32'd0, 32'd0});
        tbl.push_back('{1'b1, 4'd15, 32'd0, 32'd0});
        tbl.push_back('{1'b1, ADDR_PERIOD, 32'd0, 32'd0});
        tbl.push_back('{1'b0, ADDR_PERIOD, 32'd0, 32'd0});

        foreach (tbl[i]) begin
            if (tbl[i].wr) begin
                csr_write(tbl[i].addr, tbl[i].data, e);
            end else begin
                csr_read(tbl[i].addr, d);
                check($sformatf("csr vec%0d addr%0d", i, tbl[i].addr), d, tbl[i].exp);
            end
        end
        check("idle no pio writes", 32'(cap_d.size()), 32'd0);

        for (int i = 0; i < 4; i++) begin
            pat_m[i] = LED_W'(1 << i);
            csr_write(4'(8 + i), 32'(pat_m[i]), e);
        end
        run_seq("main", 5, 3, 1'b0, 5);
        run_seq("period0", 0, 3, 1'b0, 4);
        run_seq("period1", 1, 3, 1'b0, 4);
        run_seq("oneshot", 5, 3, 1'b1, 4);

        // Stop while waiting after the idx 2 write, then restart from pattern 0.
        csr_write(ADDR_PERIOD, 32'd6, e);
        cap_t.delete(); cap_d.delete();
        csr_write(ADDR_CTRL, 32'h31, e);
        wait_writes(3, 40);
        csr_write(ADDR_CTRL, 32'h30, e);
        repeat (15) @(negedge clk);
        check("stop write count", 32'(cap_d.size()), 32'd3);
        csr_read(ADDR_STATUS, d);
        check("stop status", d, 32'd0);
        cap_t.delete(); cap_d.delete();
        csr_write(ADDR_CTRL, 32'h31, e);
        wait_writes(1, 20);
        check("rerun first time", (cap_t.size() > 0) ? 32'(cap_t[0]) : 32'hFFFF_FFFF, 32'(e + 1));
        check("rerun first data", (cap_d.size() > 0) ? cap_d[0] : 32'hFFFF_FFFF, 32'(pat_m[0]));
        csr_write(ADDR_CTRL, 32'h30, e);
        repeat (4) @(negedge clk);

`ifdef LEDSEQ_HOST_OVERRIDE_EN
        cap_t.delete(); cap_d.delete();
        csr_write(ADDR_CTRL, 32'h31, e);
        wait_writes(2, 40);
        csr_write(ADDR_OVR, 32'h1AA, e);
        repeat (12) @(negedge clk);
        check("ovr write count", 32'(cap_d.size()), 32'd3);
        check("ovr write time", (cap_t.size() > 2) ? 32'(cap_t[2]) : 32'hFFFF_FFFF, 32'(e));
        check("ovr write data", (cap_d.size() > 2) ? cap_d[2] : 32'hFFFF_FFFF, 32'hAA);
        csr_read(ADDR_OVR, d);
        check("ovr readback", d, 32'h1AA);
        csr_write(ADDR_OVR, 32'h000, e2);
        wait_writes(5, 40);
        check("ovr rewrite time", (cap_t.size() > 3) ? 32'(cap_t[3]) : 32'hFFFF_FFFF, 32'(e2));
        check("ovr rewrite data", (cap_d.size() > 3) ? cap_d[3] : 32'hFFFF_FFFF, 32'(pat_m[1]));
        check("ovr resume data", (cap_d.size() > 4) ? cap_d[4] : 32'hFFFF_FFFF, 32'(pat_m[2]));
        csr_write(ADDR_CTRL, 32'h30, e);
        repeat (4) @(negedge clk);
`else
        cap_t.delete(); cap_d.delete();
        csr_write(ADDR_OVR, 32'h1AA, e);
        repeat (5) @(negedge clk);
        check("addr3 no pio write", 32'(cap_d.size()), 32'd0);
        csr_read(ADDR_OVR, d);
        check("addr3 reads zero", d, 32'd0);
`endif

        for (int it = 0; it < 6; it++) begin
            int per, last;
            bit os;
            for (int i = 0; i < DEPTH; i++) begin
                pat_m[i] = LED_W'($urandom);
                csr_write(4'(8 + i), 32'(pat_m[i]), e);
            end
            per  = int'($urandom_range(0, 7));
            last = int'($urandom_range(0, DEPTH - 1));
            os   = 1'($urandom_range(0, 1));
            run_seq($sformatf("rand%0d", it), per, last, os, os ? last + 1 : last + 3);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
